// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter sending one frame (start, LSB-first data, optional parity, stop bits) per accepted byte
// Ports: clk rising-edge clock; rst asynchronous active-low reset;
//        i_data/i_valid/o_ready byte handshake, accepted when i_valid && o_ready at a clock edge;
//        o_tx registered serial line (idle 1); o_busy frame in progress; o_done one-cycle pulse after the last stop bit.
module uart_tx_ctrl #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);
  typedef logic [3:0] count_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);
  localparam count_t DATA_LAST = count_t'(DATA_BITS - 1);
  localparam count_t STOP_LAST = count_t'(STOP_BITS - 1);
  state_t state, nxt;
  logic [15:0] cnt, cnt_nxt;
  count_t idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic par, par_nxt, tx_nxt, done_nxt, tick, accept;
  always_comb begin
    tick = cnt == DIV_LAST;
    accept = state == IDLE && i_valid;
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = tick && idx == DATA_LAST ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  nxt = tick ? STOP : PARITY;
      STOP:    nxt = tick && idx == STOP_LAST ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
    cnt_nxt = state == IDLE || tick ? '0 : cnt + 16'd1;
    // the bit index restarts at every state change so it can count data bits and then stop bits
    idx_nxt = state == IDLE || (tick && nxt != state) ? '0 : tick ? idx + 4'd1 : idx;
    shift_nxt = accept ? i_data : state == DATA && tick ? shift >> 1 : shift;
    // parity comes from a copy taken at acceptance because the shift register is consumed by then
    par_nxt = accept ? ^i_data ^ (PARITY_ODD != 0) : par;
    // o_tx is registered from next-state values so the line changes together with the state
    tx_nxt = nxt == START ? 1'b0 : nxt == DATA ? shift_nxt[0] : nxt == PARITY ? par_nxt : 1'b1;
    done_nxt = state == STOP && nxt == IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      par <= 1'b0;
      o_tx <= 1'b1;
      o_done <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      shift <= shift_nxt;
      par <= par_nxt;
      o_tx <= tx_nxt;
      o_done <= done_nxt;
    end
  assign o_ready = state == IDLE;
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl over five parameter sets at BAUD_DIV=4
module tb_uart_tx_ctrl;
  typedef struct {
    int u;
    logic [7:0] d;
    logic [11:0] bits;
    int nb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data [5];
  logic [4:0] valid = '0;
  logic [4:0] ready, tx, busy, done;
  int errors = 0;
  int checks = 0;
  vec_t vecs [9];
  always #5 clk = ~clk;
  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N1, u4: 8N2
  uart_tx_ctrl #(.BAUD_DIV(4)) u0 (
    .clk(clk), .rst(rst), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
  uart_tx_ctrl #(.BAUD_DIV(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
  uart_tx_ctrl #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
  uart_tx_ctrl #(.BAUD_DIV(4), .DATA_BITS(7)) u3 (
    .clk(clk), .rst(rst), .i_data(data[3][6:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));
  uart_tx_ctrl #(.BAUD_DIV(4), .STOP_BITS(2)) u4 (
    .clk(clk), .rst(rst), .i_data(data[4]), .i_valid(valid[4]),
    .o_ready(ready[4]), .o_tx(tx[4]), .o_busy(busy[4]), .o_done(done[4]));
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  // called at the negedge of the first cycle after acceptance; ends at the negedge of the o_done cycle
  task automatic check_frame(input int u, input logic [11:0] bits, input int nb);
    logic [2:0] exp;
    for (int c = 1; c <= nb * 4 + 1; c++) begin
      if (c > 1) @(negedge clk);
      exp = c <= nb * 4 ? {bits[(c - 1) / 4], 2'b10} : 3'b101;
      chk($sformatf("u%0d cycle %0d {tx,busy,done}", u, c), {5'b0, tx[u], busy[u], done[u]}, {5'b0, exp});
    end
  endtask
  task automatic send(input int u, input logic [7:0] d, input logic [11:0] bits, input int nb);
    @(negedge clk);
    chk($sformatf("u%0d ready before send", u), {7'b0, ready[u]}, 8'd1);
    data[u] = d;
    valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[u] = 1'b0;
    data[u] = ~d;
    check_frame(u, bits, nb);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int nbusy, ndone;
    vecs[0] = '{0, 8'hA5, 12'h34A, 10};
    vecs[1] = '{0, 8'h00, 12'h200, 10};
    vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
    vecs[3] = '{1, 8'h07, 12'h60E, 11};
    vecs[4] = '{1, 8'h03, 12'h406, 11};
    vecs[5] = '{2, 8'h07, 12'h40E, 11};
    vecs[6] = '{2, 8'h03, 12'h606, 11};
    vecs[7] = '{3, 8'h55, 12'h1AA, 9};
    vecs[8] = '{3, 8'h0F, 12'h11E, 9};
    for (int i = 0; i < 5; i++) data[i] = 8'h00;
    // reset held with a pending request
    valid[0] = 1'b1;
    data[0] = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("reset {tx,ready,busy,done}", {4'b0, tx[0], ready[0], busy[0], done[0]}, 8'b1100);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    data[0] = 8'h00;
    check_frame(0, 12'h34A, 10);
    for (int i = 0; i < 9; i++) send(vecs[i].u, vecs[i].d, vecs[i].bits, vecs[i].nb);
    // back-to-back with i_valid held and i_data changed mid-frame
    @(negedge clk);
    data[4] = 8'h00;
    valid[4] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data[4] = 8'hFF;
    check_frame(4, 12'h600, 11);
    chk("b2b ready in done cycle", {7'b0, ready[4]}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    valid[4] = 1'b0;
    data[4] = 8'h12;
    check_frame(4, 12'h7FE, 11);
    // reset during data bit 3
    @(negedge clk);
    data[0] = 8'hA5;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset {tx,busy} in bit 3", {6'b0, tx[0], busy[0]}, 8'b01);
    #1 rst = 1'b0;
    #1 chk("async reset {tx,busy,ready,done}", {4'b0, tx[0], busy[0], ready[0], done[0]}, 8'b1010);
    @(negedge clk);
    chk("reset held {tx,busy}", {6'b0, tx[0], busy[0]}, 8'b10);
    rst = 1'b1;
    send(0, 8'h3C, 12'h278, 10);
    // request pulse while busy must be ignored
    @(negedge clk);
    data[0] = 8'h3C;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      nbusy += int'(busy[0]);
      ndone += int'(done[0]);
      if (c == 10) begin
        valid[0] = 1'b1;
        data[0] = 8'hFF;
      end
      if (c == 11) valid[0] = 1'b0;
    end
    chk("ignored request busy cycles", 8'(nbusy), 8'd40);
    chk("ignored request done pulses", 8'(ndone), 8'd1);
    chk("ignored request final {ready,tx}", {6'b0, ready[0], tx[0]}, 8'b11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that sequences one serial frame per accepted byte: start bit, LSB-first data bits, optional parity, then stop bit(s).
- Owns the baud-rate divider and the 4-bit bit-index counter (count_t width) that selects the data bit on the line.
- Sits between the host-side valid/ready byte interface and the TX pin.
- Shares clk/rst and pkg_uart types with the rest of the UART.

Parameters:
BAUD_DIV, 434, clk cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 = append a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_data  input  DATA_BITS  byte to send; sampled only on acceptance.
i_valid  input  1  host has a byte.
o_ready  output  1  controller can accept a byte (IDLE state).
o_tx  output  1  serial line; idle level 1.
o_busy  output  1  frame in progress (any state other than IDLE).
o_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0, asynchronous, active-low; clock clk) forces these values immediately, including mid-frame:
  - state=IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - Baud counter=0, bit index=0, shift register=0.
  - A partially sent frame is dropped, not resumed.
- Acceptance: i_valid && o_ready sampled at a rising edge.
  - The data is latched into the shift register; later changes to i_data are ignored.
  - The baud counter and bit index are cleared.
  - The FSM moves to START.
  - i_valid while busy is ignored; the host holds it until o_ready.
- Baud counter:
  - Counts 0..BAUD_DIV-1 in every non-IDLE state.
  - bit_tick is true when the count equals BAUD_DIV-1.
  - The count wraps to 0 on bit_tick.
- FSM states and transitions:
  - IDLE: o_tx=1. Exit on acceptance.
  - START: o_tx=0. On bit_tick -> DATA.
  - DATA: o_tx=shift[0], so data goes out LSB first.
    - On bit_tick: shift right by one and increment the bit index.
    - When bit_tick occurs with bit index = DATA_BITS-1: clear the bit index, then go to PARITY if PARITY_EN, else STOP.
  - PARITY: o_tx = XOR of the latched data, inverted when PARITY_ODD. The parity is computed from a copy latched at acceptance, not from the shifted register. On bit_tick -> STOP.
  - STOP: o_tx=1.
    - The bit index counts stop bits.
    - When bit_tick occurs with index = STOP_BITS-1 -> IDLE, and o_done is asserted for that following IDLE cycle.
- Timing:
  - o_tx reflects the new state one cycle after acceptance, as a registered output.
  - Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) * BAUD_DIV cycles.
  - o_done and o_ready are both 1 in the first IDLE cycle, so back-to-back frames have exactly one idle clock between the last stop cycle and the next start bit.
- Outputs:
  - o_busy = (state != IDLE).
  - o_ready = (state == IDLE).
  - o_tx is registered and glitch-free.
- The bit index never exceeds 7. Counter width is 4 bits, so no wrap is possible for legal parameters.

Test Plan:
1. Reset state: BAUD_DIV=4, assert rst low for 3 cycles, with i_valid=1 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 during reset. First acceptance occurs at the first edge after release.
2. 8N1 frame: send 0xA5 -> o_tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. o_done pulses 41 cycles after acceptance; o_busy is high for exactly 40 cycles.
3. Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1, parity bit 0. Frame is 44 cycles. DATA_BITS=7 with 0x55 -> 7 data bits, then stop.
4. Back-to-back: hold i_valid=1 with 0x00 then 0xFF, STOP_BITS=2 -> two 44-cycle frames separated by exactly one idle cycle at o_tx=1. i_data changes mid-frame do not affect the first frame.
5. Reset mid-frame: assert rst during DATA bit 3 -> o_tx=1 and o_busy=0 immediately (asynchronous). After release, a new byte is sent from its start bit with correct timing.
6. Ignored request: pulse i_valid for one cycle while o_busy=1 -> no second frame, o_done pulses once.
